// File: rtl/snn_cfg_sequencer.sv
// snn_cfg_sequencer: host byte-stream decoder that writes network config registers and gates spikes.
// Define SNN_CFG_TIMEOUT_EN to abort stalled frames after TIMEOUT_CYCLES idle cycles.
module snn_cfg_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_valid,
    input  logic [7:0] s_data,
    output logic       s_ready,
    output logic [3:0] cfg_addr,
    output logic [7:0] cfg_data,
    output logic       cfg_we,
    input  logic [2:0] spikes_in,
    output logic [2:0] spikes_gated,
    output logic       net_enable,
    output logic       busy,
    output logic       err
);
    typedef enum logic {IDLE, DATA} state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    state_t     state, state_n;
    logic [3:0] addr, addr_n, cnt, cnt_n, cfg_addr_n;
    logic [7:0] cfg_data_n;
    logic       cfg_we_n, en_n, err_n, xfer;
`ifdef SNN_CFG_TIMEOUT_EN
    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] idle_cnt, idle_n;
`endif

    assign busy         = state == DATA;
    assign spikes_gated = net_enable ? spikes_in : 3'b000;
    assign xfer         = s_valid && s_ready;

    always_comb begin
        state_n    = state;
        addr_n     = addr;
        cnt_n      = cnt;
        cfg_addr_n = cfg_addr;
        cfg_data_n = cfg_data;
        cfg_we_n   = 1'b0;
        en_n       = net_enable;
        err_n      = err;
`ifdef SNN_CFG_TIMEOUT_EN
        idle_n     = 8'd0;
`endif
        if (state == IDLE) begin
            if (xfer) begin
                if (s_data[7:4] != 4'hF) begin
                    state_n = DATA;
                    addr_n  = s_data[7:4];
                    cnt_n   = s_data[3:0];
                    en_n    = 1'b0;
                end else if (s_data[3:0] == 4'h0) begin
                    en_n = 1'b1;
                end else if (s_data[3:0] == 4'h1) begin
                    en_n  = 1'b0;
                    err_n = 1'b0;
                end else begin
                    err_n = 1'b1;
                end
            end
        end else begin
            if (xfer) begin
                // address 15 is reserved: swallow the byte, flag it, keep counting
                if (addr == 4'hF) begin
                    err_n = 1'b1;
                end else begin
                    cfg_we_n   = 1'b1;
                    cfg_addr_n = addr;
                    cfg_data_n = s_data;
                end
                addr_n = addr + 4'd1;
                cnt_n  = cnt - 4'd1;
                if (cnt == 4'd0) state_n = IDLE;
            end
`ifdef SNN_CFG_TIMEOUT_EN
            else if (idle_cnt == IDLE_LAST) begin
                state_n = IDLE;
                err_n   = 1'b1;
            end else begin
                idle_n = idle_cnt + 8'd1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            addr       <= 4'd0;
            cnt        <= 4'd0;
            cfg_addr   <= 4'd0;
            cfg_data   <= 8'd0;
            cfg_we     <= 1'b0;
            net_enable <= 1'b0;
            err        <= 1'b0;
            s_ready    <= 1'b0;
`ifdef SNN_CFG_TIMEOUT_EN
            idle_cnt   <= 8'd0;
`endif
        end else begin
            state      <= state_n;
            addr       <= addr_n;
            cnt        <= cnt_n;
            cfg_addr   <= cfg_addr_n;
            cfg_data   <= cfg_data_n;
            cfg_we     <= cfg_we_n;
            net_enable <= en_n;
            err        <= err_n;
            s_ready    <= 1'b1;
`ifdef SNN_CFG_TIMEOUT_EN
            idle_cnt   <= idle_n;
`endif
        end
    end
endmodule

// File: doc/snn_cfg_sequencer.md
SNN_CFG_SEQUENCER -- requirements
Module: snn_cfg_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: idle cycles tolerated mid-frame before abort (8-bit counter range, 1..255).
REQ-002 clk  input  1  single clock; all logic on posedge clk.
REQ-003 reset  input  1  synchronous, active-low reset.
REQ-004 s_valid  input  1  host byte valid.
REQ-005 s_data  input  8  host byte (header or payload).
REQ-006 s_ready  output  1  sequencer can accept a byte this cycle.
REQ-007 cfg_addr  output  4  network parameter register address (0..14 legal).
REQ-008 cfg_data  output  8  network parameter register write data.
REQ-009 cfg_we  output  1  one-cycle write strobe to the network register file.
REQ-010 spikes_in  input  3  raw input spikes from pads.
REQ-011 spikes_gated  output  3  spikes forwarded to the network; equals spikes_in when net_enable=1, else 3'b000 (combinational).
REQ-012 net_enable  output  1  network run enable.
REQ-013 busy  output  1  high while in state DATA.
REQ-014 err  output  1  sticky error flag.

Function
REQ-015 Transfer occurs on a cycle with s_valid=1 and s_ready=1; s_ready SHALL be 1 in IDLE and DATA, 0 only during reset.
REQ-016 FSM states: IDLE (await header), DATA (receive payload).
REQ-017 In IDLE, an accepted header with s_data[7:4]!=4'hF is a write header: start address A=s_data[7:4], count N=s_data[3:0]+1 (1..16); go to DATA, clear net_enable in the same edge.
REQ-018 In IDLE, header 8'hF0 = COMMIT: net_enable<=1, stay IDLE.
REQ-019 In IDLE, header 8'hF1 = HALT: net_enable<=0, err<=0, stay IDLE.
REQ-020 In IDLE, headers 8'hF2..8'hFF are illegal: err<=1, no other effect.
REQ-021 In DATA, the k-th accepted payload byte (k=0..N-1) SHALL produce, on the next cycle, cfg_we=1, cfg_addr=(A+k) mod 16, cfg_data=that byte; latency 1 cycle, registered outputs.
REQ-022 Back-to-back payload bytes SHALL produce back-to-back cfg_we pulses with no bubble.
REQ-023 Payload addressed to 15 SHALL be consumed without cfg_we and SHALL set err; the address counter continues (wraps 15->0).
REQ-024 After the N-th payload byte is accepted, FSM returns to IDLE on the same edge; the next byte is a header.
REQ-025 cfg_we SHALL be 0 on all cycles not given by REQ-021; cfg_addr/cfg_data hold their last values when cfg_we=0.
REQ-026 Idle counter: in DATA, counts cycles without a transfer, cleared on each transfer; reaching TIMEOUT_CYCLES aborts to IDLE, sets err, discards remaining count.
REQ-027 net_enable is never set by a write frame; only COMMIT sets it.
REQ-028 busy=1 exactly while state=DATA.

Reset
REQ-029 On clk edge with reset=0: state=IDLE, cfg_we=0, cfg_addr=0, cfg_data=0, net_enable=0, err=0, idle counter=0, s_ready=0.
REQ-030 Reset mid-frame SHALL abandon the frame; no cfg_we is issued on the cycle after reset is asserted or while reset=0.
REQ-031 s_ready=1 from the first cycle after reset deasserts.

Configuration
REQ-032 Macro SNN_CFG_TIMEOUT_EN: when defined, REQ-026 is implemented; when undefined, no idle counter exists and DATA waits indefinitely for payload.

Verification
REQ-033 Header 8'h32 then bytes 8'h10,8'h20,8'h30 back-to-back -> cfg_we pulses on 3 consecutive cycles at addr 3,4,5 with data 10,20,30; busy falls after third accept; err=0.
REQ-034 COMMIT 8'hF0 then spikes_in=3'b101 -> net_enable=1 next cycle, spikes_gated=3'b101; then header 8'h00 -> net_enable=0, spikes_gated=3'b000.
REQ-035 Header 8'hE2, payload 8'hAA,8'hBB,8'hCC -> writes addr 14 (AA), none for 15 (BB), addr 0 (CC); err=1 after BB; HALT 8'hF1 clears err.
REQ-036 Header 8'h04 (N=5), send 2 bytes, stall s_valid=0 for 255 cycles -> with SNN_CFG_TIMEOUT_EN: IDLE, err=1, no further cfg_we; next byte 8'hF0 treated as COMMIT; without macro: still busy.
REQ-037 Header 8'h02, one payload byte, reset=0 for 1 cycle, then byte 8'h55 -> no cfg_we, 8'h55 decoded as header (start 5, N=6), busy=1.
REQ-038 Illegal header 8'hF7 in IDLE -> err=1, net_enable unchanged, no cfg_we, state IDLE.
